// File: rtl/inst_loader.sv
// Boot-time instruction loader: parses a framed byte stream (magic, 16-bit word count,
// payload, checksum) and writes packed 32-bit words into instruction memory.
module inst_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StCsum, StDone, StErr
  } state_e;

  state_e                state_d, state_q;
  logic [15:0]           count_d, count_q;
  logic [ADDR_WIDTH:0]   idx_d, idx_q;
  logic [ADDR_WIDTH:0]   idx_inc;
  logic [1:0]            bcnt_d, bcnt_q;
  logic [23:0]           word_d, word_q;
  logic [7:0]            csum_d, csum_q;
  logic                  we_d, we_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [31:0]           wdata_d, wdata_q;
  logic                  hold_d, hold_q;
  logic                  done_d, done_q;
  logic                  err_d, err_q;
  logic                  rdy_q;
  logic                  take;
  logic [15:0]           len_full;

  assign take     = rx_valid && rdy_q;
  assign len_full = {count_q[15:8], rx_data};
  assign idx_inc  = idx_q + 1'b1;

  // Parse the frame one consumed byte at a time; the write strobe defaults low.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    if (take) begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (rx_data == MAGIC) begin
            state_d = StLenHi;
            done_d  = 1'b0;
            err_d   = 1'b0;
            csum_d  = 8'h00;
            idx_d   = '0;
            bcnt_d  = 2'd0;
            hold_d  = 1'b1;
          end
        end
        StLenHi: begin
          count_d[15:8] = rx_data;
          state_d       = StLenLo;
        end
        StLenLo: begin
          count_d[7:0] = rx_data;
          if (32'(len_full) > (32'd1 << ADDR_WIDTH)) begin
            state_d = StErr;
            err_d   = 1'b1;
            hold_d  = 1'b0;
          end else if (len_full == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          csum_d = csum_q + rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {word_q, rx_data};
            addr_d  = idx_q[ADDR_WIDTH-1:0];
            idx_d   = idx_inc;
            if (32'(idx_inc) == 32'(count_q)) state_d = StCsum;
          end else begin
            word_d = {word_q[15:0], rx_data};
          end
        end
        StCsum: begin
          hold_d = 1'b0;
          if (rx_data == csum_q) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers; reset drops any partial word and clears every output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  // Outputs come straight from registers; byte address is the word index shifted by two.
  always_comb begin
    rx_ready  = rdy_q;
    mem_we    = we_q;
    mem_addr  = {{(30 - ADDR_WIDTH){1'b0}}, addr_q, 2'b00};
    mem_wdata = wdata_q;
    cpu_hold  = hold_q;
    done      = done_q;
    error     = err_q;
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed frames plus randomized frames, checked
// against a frame-level reference model.
module tb_inst_loader;
  localparam int unsigned AW = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  inst_loader #(.ADDR_WIDTH(AW), .MAGIC(8'hA5)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clock) begin
    if (mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      obs_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err;

  // Frame-level model: locate magic, read count, slice payload into words, sum bytes.
  task automatic model(input logic [7:0] s[$]);
    int m, p;
    int unsigned cnt, sum;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    m = 0;
    while (s[m] != 8'hA5) m++;
    cnt = {s[m+1], s[m+2]};
    if (cnt > (32'd1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    sum = 0;
    p   = m + 3;
    for (int w = 0; w < int'(cnt); w++) begin
      exp_addr.push_back(32'(4 * w));
      exp_data.push_back({s[p], s[p+1], s[p+2], s[p+3]});
      sum += s[p] + s[p+1] + s[p+2] + s[p+3];
      p += 4;
    end
    exp_done = (s[p] == sum[7:0]);
    exp_err  = !exp_done;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (gaps) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic run_frame(input logic [7:0] s[$], input int gap_max, input string name);
    int m;
    model(s);
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    m = 0;
    while (s[m] != 8'hA5) m++;
    foreach (s[i]) begin
      send_byte(s[i], gap_max);
      if (i == m + 1) begin
        // Magic has been consumed on the previous edge.
        check({name, ".hold_in_frame"}, 32'(cpu_hold), 32'd1);
        check({name, ".done_cleared"}, 32'(done), 32'd0);
        check({name, ".error_cleared"}, 32'(error), 32'd0);
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
    check({name, ".done"}, 32'(done), 32'(exp_done));
    check({name, ".error"}, 32'(error), 32'(exp_err));
    check({name, ".hold_end"}, 32'(cpu_hold), 32'd0);
    check({name, ".n_writes"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    if (obs_addr.size() == exp_addr.size()) begin
      foreach (exp_addr[i]) begin
        check($sformatf("%s.addr%0d", name, i), obs_addr[i], exp_addr[i]);
        check($sformatf("%s.data%0d", name, i), obs_data[i], exp_data[i]);
        if (gap_max == 0 && i > 0)
          check($sformatf("%s.spacing%0d", name, i), 32'(obs_cyc[i] - obs_cyc[i-1]), 32'd4);
      end
      if (exp_addr.size() > 0) begin
        check({name, ".addr_hold"}, mem_addr, exp_addr[exp_addr.size()-1]);
        check({name, ".data_hold"}, mem_wdata, exp_data[exp_data.size()-1]);
      end
    end
  endtask

  task automatic build_frame(input int cnt, input bit good, input int junk,
                             output logic [7:0] f[$]);
    logic [7:0] b, sum;
    f.delete();
    for (int j = 0; j < junk; j++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      f.push_back(b);
    end
    f.push_back(8'hA5);
    f.push_back(8'(cnt >> 8));
    f.push_back(8'(cnt));
    if (cnt > (1 << AW)) return;
    sum = 8'h00;
    for (int j = 0; j < 4 * cnt; j++) begin
      b = 8'($urandom);
      sum += b;
      f.push_back(b);
    end
    f.push_back(good ? sum : sum + 8'($urandom_range(1, 255)));
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".mem_we"}, 32'(mem_we), 32'd0);
    check({name, ".mem_addr"}, mem_addr, 32'd0);
    check({name, ".mem_wdata"}, mem_wdata, 32'd0);
    check({name, ".cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({name, ".done"}, 32'(done), 32'd0);
    check({name, ".error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] f[$];
    int cnt;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst.rx_ready", 32'(rx_ready), 32'd0);
    check_idle_outputs("rst");
    reset = 1'b1;
    @(negedge clock);
    check("rel.rx_ready", 32'(rx_ready), 32'd1);

    // Junk ahead of any frame is ignored.
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    @(negedge clock);
    rx_valid = 1'b0;
    check_idle_outputs("junk");

    f = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
    run_frame(f, 0, "one_word");
    f = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    run_frame(f, 0, "two_words");
    run_frame(f, 3, "two_words_gaps");
    f[11] = 8'h25;
    run_frame(f, 0, "bad_csum");
    f = '{8'hA5, 8'h04, 8'h01};
    run_frame(f, 0, "oversize");
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame(f, 0, "empty");

    // Reset in the middle of a word: nothing is written, outputs clear at once.
    obs_addr.delete();
    f = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
    foreach (f[i]) send_byte(f[i], 0);
    @(negedge clock);
    rx_valid = 1'b0;
    check("midrst.hold_before", 32'(cpu_hold), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst.rx_ready", 32'(rx_ready), 32'd0);
    check_idle_outputs("midrst");
    repeat (2) @(negedge clock);
    check("midrst.no_write", 32'(obs_addr.size()), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    f = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14};
    run_frame(f, 0, "after_rst");

    // Largest legal image fills the whole memory.
    build_frame(1 << AW, 1'b1, 0, f);
    run_frame(f, 0, "full");

    // Randomized frames with junk, gaps, bad checksums and oversize counts.
    for (int k = 0; k < 30; k++) begin
      cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1025, 65535))
                                        : int'($urandom_range(0, 12));
      build_frame(cnt, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), f);
      run_frame(f, ($urandom_range(0, 1) == 1) ? 3 : 0, $sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that fills the single-cycle MIPS instruction memory from a byte stream (UART receiver or host bridge). It parses a framed image (magic byte, word count, payload, checksum), packs payload bytes into 32-bit words and issues one write per word into the instruction RAM's write port. It holds the processor off (`cpu_hold`) while an image is in flight. It is the writer-side counterpart of the instruction ROM read path: stored words use the same byte layout as the `.memh` images, so the fetch-side byte flip yields the correct instruction.

## Interface
- `ADDR_WIDTH`, 10, word-address width of instruction memory; capacity 2**ADDR_WIDTH words
- `MAGIC`, 8'hA5, frame start byte
- `clock` input 1: sole clock, rising edge
- `reset` input 1: asynchronous, active-low; clears all state
- `rx_data` input 8: stream byte
- `rx_valid` input 1: `rx_data` valid this cycle; a byte is consumed when `rx_valid && rx_ready`
- `rx_ready` output 1: loader can accept a byte
- `mem_we` output 1: one-cycle write strobe to instruction memory
- `mem_addr` output 32: byte address, `{word_index, 2'b00}`, zero-extended
- `mem_wdata` output 32: word to write
- `cpu_hold` output 1: high while a frame is in progress
- `done` output 1: last frame completed with a good checksum
- `error` output 1: last frame failed (oversize count or bad checksum)

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- `rx_ready` is 1 in every state, so a byte can be consumed every cycle.
- IDLE / DONE / ERR:
  - A consumed byte equal to `MAGIC` moves to LEN_HI.
  - On that move: clear `done`, `error`, the checksum, the word index and the byte counter; set `cpu_hold`.
  - Any other byte is discarded and the state is unchanged.
- LEN_HI: byte becomes count[15:8]; go to LEN_LO.
- LEN_LO: byte becomes count[7:0]. Then:
  - count > 2**ADDR_WIDTH: go to ERR.
  - count == 0: go to CSUM.
  - otherwise: go to DATA.
- DATA:
  - Each byte is added to the 8-bit checksum, modulo 256.
  - Bytes are packed MSB-first: the 1st byte of a word goes to [31:24] and the 4th to [7:0].
  - After the 4th byte: write the word at the current word index, then increment the index.
  - When index == count after that write, go to CSUM.
- CSUM:
  - Received byte equals the running sum: go to DONE and set `done`.
  - Otherwise: go to ERR and set `error`.
  - `cpu_hold` clears in both cases.
- On entering ERR from LEN_LO, `cpu_hold` also clears.
- Header bytes and the checksum byte are not summed.
- Writes already issued are never rolled back. On error, memory contents are undefined for the processor and must not be used.
- Reset mid-frame:
  - All outputs go low immediately and the state returns to IDLE.
  - A partial word is dropped with no write.
  - Memory is untouched beyond words already written.

## Timing
- Reset values: `rx_ready`=0 while `reset` is low and 1 after release; `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `done`=0, `error`=0.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. The strobe is high for exactly the one cycle after the clock edge that consumes the 4th byte of a word.
- `mem_addr` and `mem_wdata` hold their value until the next write.
- Back-to-back bytes produce a write every 4 cycles. Gaps in `rx_valid` only stretch this spacing.
- `cpu_hold` rises on the edge that consumes `MAGIC`.
- `cpu_hold` falls, and `done` or `error` rises, on the edge that consumes the checksum byte. For an oversize count, this happens on the edge that consumes LEN_LO.
- `done` and `error` are levels, mutually exclusive, and held until the next `MAGIC` or reset.
- Byte counter wraps 3→0; word index has ADDR_WIDTH+1 bits, so count == 2**ADDR_WIDTH is legal and the last address is 4·(2**ADDR_WIDTH−1).

## Test plan
- Reset release, then stream A5 00 01 12 34 56 78 14 (no idle cycles):
  - One `mem_we` pulse with `mem_addr`=0 and `mem_wdata`=32'h12345678.
  - Then `done`=1, `error`=0, `cpu_hold`=0.
- Stream A5 00 02 followed by 8 data bytes 01..08 and checksum 24:
  - Writes 32'h01020304 at 0 and 32'h05060708 at 4.
  - Writes are spaced 4 cycles apart; `done`=1.
  - Repeat with random `rx_valid` gaps: same writes, same result.
- Same frame with a checksum of 25: both writes occur, then `error`=1, `done`=0, `cpu_hold`=0.
- Oversize and empty frames:
  - A5 04 01 (count 1025 with ADDR_WIDTH 10): `error`=1 after the 3rd byte, no `mem_we`.
  - A5 00 00 00: `done`=1, no writes.
- Junk and reload:
  - Bytes 00 FF 5A before a valid frame: ignored, outputs stay at reset values.
  - A second valid frame after DONE: `done` clears on `MAGIC`, writes restart at address 0.
- Reset mid-frame:
  - Assert `reset` after A5 00 01 12 34: outputs clear asynchronously, no write.
  - A following full frame loads correctly.
